// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: ExUnit store entry, ROB commit/flush, load-forward lookup, data-memory write.
// Latency: none (wires only).
// Backpressure: st_ready_o gates st_valid_i; the data-memory write is never stalled.
interface store_buffer_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                st_valid_i;
  logic [ADDR_LEN-1:0] st_addr_i;
  logic [DATA_LEN-1:0] st_data_i;
  logic                st_ready_o;
  logic                commit_i;
  logic                kill_i;
  logic [ADDR_LEN-1:0] ld_addr_i;
  logic                fwd_hit_o;
  logic [DATA_LEN-1:0] fwd_data_o;
  logic                dmem_we_o;
  logic [ADDR_LEN-1:0] dmem_addr_o;
  logic [DATA_LEN-1:0] dmem_wdata_o;
  logic                empty_o;
  logic                commit_err_o;

  // Pipeline / ROB / memory side
  modport master (
    output st_valid_i, st_addr_i, st_data_i, commit_i, kill_i, ld_addr_i,
    input  st_ready_o, fwd_hit_o, fwd_data_o, dmem_we_o, dmem_addr_o,
    input  dmem_wdata_o, empty_o, commit_err_o
  );

  // Store buffer side
  modport slave (
    input  st_valid_i, st_addr_i, st_data_i, commit_i, kill_i, ld_addr_i,
    output st_ready_o, fwd_hit_o, fwd_data_o, dmem_we_o, dmem_addr_o,
    output dmem_wdata_o, empty_o, commit_err_o
  );
endinterface

// File: rtl/store_buffer.sv
// Speculative word store buffer: circular queue (head/cmt/tail), in-order drain of committed stores.
// Latency: a store committed at edge E writes memory in the cycle after E once older stores drained; forwarding is combinational.
// Backpressure: st_ready_o low when all ENTRY_NUM slots are occupied; a drain does not free a slot in the same cycle.
// Optional load forwarding enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int ENTRY_NUM = 8,
  parameter int ADDR_LEN  = 32,
  parameter int DATA_LEN  = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  store_buffer_if.slave sb
);

  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ENTRY_NUM);

  // Queue pointers and occupancy. ucnt_q counts uncommitted entries (cmt..tail);
  // it disambiguates cmt == tail on a full buffer and gives head's commit status:
  // the committed entries are always the oldest count_q - ucnt_q ones.
  logic [PTR_W-1:0] head_q, cmt_q, tail_q;
  logic [PTR_W-1:0] head_n, cmt_n, tail_n;
  logic [CNT_W-1:0] count_q, ucnt_q;
  logic [CNT_W-1:0] count_n, ucnt_n, ucnt_after;
  logic             commit_err_q;

  logic [ADDR_LEN-1:0] addr_mem [ENTRY_NUM];
  logic [DATA_LEN-1:0] data_mem [ENTRY_NUM];

  logic ready;
  logic push;
  logic commit_ok;
  logic commit_bad;
  logic drain;

  // Per-cycle events, all decided from current state only
  always_comb begin
    ready      = (count_q != FULL);
    push       = sb.st_valid_i && ready && !sb.kill_i;
    commit_ok  = sb.commit_i && (ucnt_q != '0);
    commit_bad = sb.commit_i && (ucnt_q == '0);
    drain      = (count_q != ucnt_q);
    ucnt_after = ucnt_q - CNT_W'(commit_ok);
  end

  // Next pointers/counts: commit first, then kill rolls tail back to the post-commit cmt
  always_comb begin
    head_n = head_q + PTR_W'(drain);
    cmt_n  = cmt_q + PTR_W'(commit_ok);
    tail_n = tail_q;
    ucnt_n = ucnt_q;
    count_n = count_q;
    if (sb.kill_i) begin
      tail_n  = cmt_n;
      ucnt_n  = '0;
      count_n = count_q - CNT_W'(drain) - ucnt_after;
    end else begin
      tail_n  = tail_q + PTR_W'(push);
      ucnt_n  = ucnt_after + CNT_W'(push);
      count_n = count_q + CNT_W'(push) - CNT_W'(drain);
    end
  end

  // Control state; reset wins over every same-cycle event
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q       <= '0;
      cmt_q        <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ucnt_q       <= '0;
      commit_err_q <= 1'b0;
    end else begin
      head_q  <= head_n;
      cmt_q   <= cmt_n;
      tail_q  <= tail_n;
      count_q <= count_n;
      ucnt_q  <= ucnt_n;
      if (commit_bad) begin
        commit_err_q <= 1'b1;
      end
    end
  end

  // Entry payload; not reset since validity comes from the pointers
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[tail_q] <= sb.st_addr_i;
      data_mem[tail_q] <= sb.st_data_i;
    end
  end

  // Status and drain port; reset forces the idle view even before state clears
  assign sb.st_ready_o   = reset_i || ready;
  assign sb.empty_o      = reset_i || (count_q == '0);
  assign sb.dmem_we_o    = !reset_i && drain;
  assign sb.dmem_addr_o  = addr_mem[head_q];
  assign sb.dmem_wdata_o = data_mem[head_q];
  assign sb.commit_err_o = commit_err_q;

`ifdef STORE_BUFFER_FWD_EN
  logic                fwd_hit;
  logic [DATA_LEN-1:0] fwd_data;
  logic [PTR_W-1:0]    fwd_idx;

  // Walk entries oldest to youngest so the last match (youngest) wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_mem[fwd_idx][ADDR_LEN-1:2] == sb.ld_addr_i[ADDR_LEN-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

  assign sb.fwd_hit_o  = !reset_i && fwd_hit;
  assign sb.fwd_data_o = reset_i ? '0 : fwd_data;
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^sb.ld_addr_i;
  assign sb.fwd_hit_o   = 1'b0;
  assign sb.fwd_data_o  = '0;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter ENTRY_NUM, default 8, store-buffer depth; a power of two, at least 2.
REQ-002 The block SHALL have parameter ADDR_LEN, default 32, address width.
REQ-003 The block SHALL have parameter DATA_LEN, default 32, data width.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset, synchronous and active-high.
REQ-006 st_valid_i  input  1  ExUnit memory-access stage presents an executed (speculative) word store.
REQ-007 st_addr_i  input  ADDR_LEN  store byte address.
REQ-008 st_data_i  input  DATA_LEN  store data.
REQ-009 st_ready_o  output  1  an entry is free to accept a store.
REQ-010 commit_i  input  1  ROB retires the oldest outstanding store.
REQ-011 kill_i  input  1  pipeline flush; discard all uncommitted stores.
REQ-012 ld_addr_i  input  ADDR_LEN  load address for the forwarding lookup.
REQ-013 fwd_hit_o  output  1  buffered store matches ld_addr_i.
REQ-014 fwd_data_o  output  DATA_LEN  forwarded store data.
REQ-015 dmem_we_o  output  1  data memory write enable.
REQ-016 dmem_addr_o  output  ADDR_LEN  data memory write address.
REQ-017 dmem_wdata_o  output  DATA_LEN  data memory write data.
REQ-018 empty_o  output  1  no valid entries in the buffer.
REQ-019 commit_err_o  output  1  sticky flag: commit_i was received with no uncommitted entry.

Function
REQ-020 Storage SHALL be a circular queue with three pointers, each taken modulo ENTRY_NUM: head (oldest entry, drain point), cmt (oldest uncommitted entry) and tail (next free entry); an occupancy count SHALL run 0..ENTRY_NUM.
REQ-021 st_ready_o SHALL equal (count != ENTRY_NUM), evaluated on current state only; a drain in the same cycle SHALL NOT free a slot early.
REQ-022 A push, defined as st_valid_i && st_ready_o && !kill_i, SHALL write addr/data at tail, mark the entry uncommitted and advance tail by 1.
REQ-023 commit_i SHALL mark the entry at cmt as committed and advance cmt by 1; if cmt equals tail (no uncommitted entry), it SHALL be ignored and SHALL set commit_err_o.
REQ-024 dmem_we_o SHALL equal (count != 0 && entry at head committed), combinationally; dmem_addr_o and dmem_wdata_o SHALL show the head entry; when dmem_we_o is high, head SHALL advance by 1 at the next edge.
REQ-025 A store committed at edge E SHALL appear on dmem_we_o in the cycle following E, provided all older entries have drained.
REQ-026 Drain rate SHALL be at most one store per cycle, strictly in program order.
REQ-027 kill_i SHALL set tail to cmt after any same-cycle commit has been applied; committed entries SHALL survive and keep draining; a same-cycle push SHALL be dropped.
REQ-028 Count SHALL update by +push -drain -killed entries in a single cycle; push, commit and drain in the same cycle SHALL all take effect.
REQ-029 Address compare SHALL use word address bits [ADDR_LEN-1:2]; byte and halfword stores are out of scope.
REQ-030 empty_o SHALL equal (count == 0).

Reset
REQ-031 On reset_i, head, cmt, tail and count SHALL be 0 and commit_err_o SHALL be 0; entry contents need not be cleared.
REQ-032 During and after reset, st_ready_o=1, dmem_we_o=0, fwd_hit_o=0, empty_o=1 and fwd_data_o=0 SHALL hold; reset SHALL override push, commit and kill in the same cycle, and any pending entries SHALL be lost.

Configuration
REQ-033 With STORE_BUFFER_FWD_EN defined, fwd_hit_o SHALL be 1 when any valid entry (committed or not, including the head draining this cycle) matches ld_addr_i, and fwd_data_o SHALL be the data of the youngest such entry; both outputs SHALL be combinational.
REQ-034 Without STORE_BUFFER_FWD_EN, fwd_hit_o and fwd_data_o SHALL be constant 0 and no compare logic SHALL be synthesized.

Verification
REQ-035 Reset, then push 0x100/0xAA, then commit one cycle later -> dmem_we_o=1 with addr 0x100 and wdata 0xAA for exactly one cycle, then empty_o=1.
REQ-036 Push 8 stores without committing -> st_ready_o=0 after the 8th; a 9th push is dropped; commit all 8 -> 8 consecutive dmem writes in order, with the pointers wrapping correctly.
REQ-037 Push A(committed), B and C (uncommitted), then kill_i -> only A is written to dmem, count=0 afterwards, and a same-cycle push D is dropped.
REQ-038 FWD_EN: push 0x200/0x11, then 0x200/0x22, with ld_addr_i=0x203 -> fwd_hit_o=1 and fwd_data_o=0x22; ld_addr_i=0x204 -> fwd_hit_o=0.
REQ-039 commit_i on an empty buffer -> no dmem write and commit_err_o=1 until reset.
REQ-040 Full buffer with head committed, push and drain in the same cycle -> push rejected and count=7 next cycle.
